mult_share_arb: RTL and testbench
=================================

// Module: mult_share_arb
// PURPOSE
//   Shares one array_multiplier instance among NREQ requesters. Round-robin picks a request,
//   launches the multiplier with a start pulse, waits for done, then returns the product
//   tagged with the requester id. Sits between client blocks and the shared multiplier.
// PARAMETERS
//   WIDTH    8    operand width; product is 2*WIDTH
//   NREQ     4    number of requesters (2..8)
//   TMO_CYC  16   watchdog limit in WAIT cycles (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1            clock
//   rst_n        in   1            synchronous, active-low reset
//   req_valid    in   NREQ         per-requester operation request
//   req_ready    out  NREQ         one-hot grant; handshake when valid&ready
//   req_a        in   NREQ*WIDTH   multiplicands, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NREQ*WIDTH   multipliers, same packing
//   rsp_valid    out  1            response available
//   rsp_ready    in   1            response consumed when valid&ready
//   rsp_id       out  $clog2(NREQ) requester index of response
//   rsp_product  out  2*WIDTH      product
//   rsp_err      out  1            timeout flag (constant 0 without MULT_ARB_TIMEOUT_EN)
//   mul_start    out  1            one-cycle start pulse to multiplier
//   mul_a        out  WIDTH        multiplicand to multiplier (held from ISSUE until next grant)
//   mul_b        out  WIDTH        multiplier operand (held likewise)
//   mul_product  in   2*WIDTH      multiplier result
//   mul_done     in   1            multiplier done level
// BEHAVIOUR
//   - Reset: state IDLE, rr pointer 0, all outputs 0 (req_ready, rsp_*, mul_*).
//   - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; exactly one operation in flight.
//   - IDLE: if any req_valid, grant first valid index at/after pointer (wrapping);
//     req_ready one-hot for that cycle only; latch operands and id; pointer <= grant+1 mod NREQ.
//     No valid: stay IDLE, req_ready=0.
//   - ISSUE: mul_start=1 for exactly one cycle, mul_a/mul_b driven from latched operands.
//   - WAIT: mul_done sampled only here (stale done in ISSUE cycle ignored). On done: capture
//     mul_product into rsp_product, go RESP.
//   - RESP: rsp_valid=1 with rsp_id/rsp_product stable until rsp_ready; on handshake go IDLE
//     (next grant possible that same IDLE cycle, i.e. 1 cycle after handshake).
//   - Latency: grant at cycle T, mul_start at T+1, rsp_valid at cycle after done seen.
//   - req_valid dropped before grant: no grant, no side effect. Requests never reordered per id.
//   - Back-pressure: rsp_ready low holds RESP indefinitely; no new grants meanwhile.
//   - Reset mid-operation: immediate return to IDLE, pending op discarded, pointer 0.
// CONFIGURATION
//   MULT_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TMO_CYC cycles without done go RESP
//     with rsp_err=1, rsp_product=0. rsp_err cleared on response handshake.
//   Not defined: no counter, WAIT indefinitely, rsp_err tied 0, TMO_CYC unused.
// STRUCTURE
//   mult_arb_pkg: state enum typedef (IDLE/ISSUE/WAIT/RESP), id width function/localparam,
//     default WIDTH/NREQ constants.
//   Sub-module rr_pick: combinational round-robin picker (valid vector + pointer -> one-hot
//     grant + index). FSM, operand/result registers and watchdog live in mult_shar_arb.
// TESTING (bench pairs with a real array_multiplier WIDTH=8)
//   1. Single req0 a=12,b=13 -> req_ready[0] 1 cycle, one mul_start, rsp id=0 product=156.
//   2. All 4 valid continuously, a=i+1,b=3 -> grants order 0,1,2,3,0; products 3,6,9,12.
//   3. rsp_ready held low 10 cycles in RESP -> rsp_valid/id/product stable, no req_ready.
//   4. Edge operands 255*255 -> 65025; 0*200 -> 0; 1*77 -> 77.
//   5. rst_n low 1 cycle during WAIT -> next cycle all outputs 0, new req0 served normally.
//   6. TIMEOUT_EN, mul_done forced 0 -> rsp_valid after 16 WAIT cycles, rsp_err=1, product 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mult_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Round-robin picker: first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sharing of one multiplier among NREQ requesters.
// Define MULT_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  NREQ    = DEF_NREQ,
  parameter int  TMO_CYC = 16,
  localparam int IDW     = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  rsp_err,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_product,
  input  logic                  mul_done
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               start_q, start_d;
  logic               vld_q, vld_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [NREQ-1:0]    pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  int                 sel;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = 1'b0;
    vld_d   = vld_q;
    prod_d  = prod_q;
    sel     = int'(pick_idx) * WIDTH;
`ifdef MULT_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_ISSUE;
          id_d    = pick_idx;
          a_d     = req_a[sel +: WIDTH];
          b_d     = req_b[sel +: WIDTH];
          start_d = 1'b1;
          ptr_d   = (pick_idx == IDW'(NREQ - 1)) ?
                    '0 : pick_idx + IDW'(1);
        end
      end
      S_ISSUE: begin
        // done may still be high from the previous op here
        state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (mul_done) begin
          state_d = S_RESP;
          vld_d   = 1'b1;
          prod_d  = mul_product;
`ifdef MULT_ARB_TIMEOUT_EN
        end else if (tmo_q == TW'(TMO_CYC - 1)) begin
          state_d = S_RESP;
          vld_d   = 1'b1;
          prod_d  = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      prod_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      prod_q  <= prod_d;
`ifdef MULT_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req_ready   = (rst_n && state_q == S_IDLE) ?
                       pick_grant : '0;
  assign rsp_valid   = vld_q;
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign mul_start   = start_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
`ifdef MULT_ARB_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with a behavioural multi-cycle multiplier.
// Build with MULT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mult_share_arb;
  import mult_arb_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_product;
  logic             rsp_err;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_product;
  logic             mul_done;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;
  int rdy_cnt = 0;
  logic force_low = 1'b0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2*W-1:0] prod;
    logic           err;
  } exp_t;

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] prod;
  } vec_t;

  exp_t sb[$];
  int   grant_log[$];
  int   rsp_log[$];

  always #5 clk = ~clk;

  mult_share_arb #(
    .WIDTH   (W),
    .NREQ    (N),
    .TMO_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  // Multiplier model: done is a level that stays high until next start
  int             mcnt;
  logic           mbusy;
  logic [2*W-1:0] mhold;
  always @(posedge clk) begin
    if (!rst_n) begin
      mul_done    <= 1'b0;
      mul_product <= '0;
      mbusy       <= 1'b0;
      mcnt        <= 0;
      mhold       <= '0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      mbusy    <= 1'b1;
      mcnt     <= LAT;
      mhold    <= 16'(mul_a) * 16'(mul_b);
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mbusy <= 1'b0;
        if (!force_low) begin
          mul_done    <= 1'b1;
          mul_product <= mhold;
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: push on grant, pop on response handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (mul_start) start_cnt++;
      if (req_ready != '0) begin
        rdy_cnt++;
        check("grant_onehot",
              32'(($onehot(req_ready) &&
                   ((req_ready & ~req_valid) == '0))), 1);
        for (int i = 0; i < N; i++) begin
          if (req_ready[i] && req_valid[i]) begin
            e.id   = IDW'(i);
            e.err  = force_low;
            e.prod = force_low ? '0 :
                     16'(req_a[i*W +: W]) * 16'(req_b[i*W +: W]);
            sb.push_back(e);
            grant_log.push_back(i);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(int'(rsp_product));
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_product", 32'(rsp_product), 32'(e.prod));
          check("sb_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic v,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
    end
    if (g == '0) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rsp_timeout", 0, 1);
  endtask

  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mul_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("start_timeout", 0, 1);
  endtask

  // One isolated request from requester i; waits for its response
  task automatic do_req(input int i,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output logic [IDW-1:0] id,
                        output logic [2*W-1:0] p);
    logic [N-1:0] g;
    logic ok;
    set_req(i, 1'b1, a, b);
    wait_grant(g);
    @(posedge clk); #1;
    set_req(i, 1'b0, '0, '0);
    wait_rsp(ok);
    id = rsp_id;
    p  = rsp_product;
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];
  int   exp_order[5];
  int   exp_prods[5];

  initial begin
    logic [IDW-1:0] id;
    logic [2*W-1:0] p;
    logic [N-1:0]   g;
    logic           ok;
    int             n;

    vecs[0] = '{0, 8'd12,  8'd13,  16'd156};
    vecs[1] = '{1, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{2, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{3, 8'd1,   8'd77,  16'd77};
    vecs[4] = '{0, 8'd200, 8'd0,   16'd0};
    vecs[5] = '{2, 8'd255, 8'd1,   16'd255};
    exp_order = '{0, 1, 2, 3, 0};
    exp_prods = '{3, 6, 9, 12, 3};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_product", 32'(rsp_product), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_mul_ab", 32'({mul_a, mul_b}), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);

    // Table: single requests, edge operands, one start per op
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      start_cnt = 0;
      rdy_cnt   = 0;
      do_req(vecs[v].id, vecs[v].a, vecs[v].b, id, p);
      check("vec_id", 32'(id), 32'(vecs[v].id));
      check("vec_product", 32'(p), 32'(vecs[v].prod));
      check("vec_rsp_err", 32'(rsp_err), 0);
      check("vec_start_pulses", 32'(start_cnt), 1);
      check("vec_ready_cycles", 32'(rdy_cnt), 1);
    end

    // All four valid continuously from pointer 0
    do_reset();
    grant_log.delete();
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i + 1), 8'd3);
    n = 0;
    while (rsp_log.size() < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = '0;
    check("rr_rsp_count", 32'(rsp_log.size()), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size())
        check("rr_grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
      if (k < rsp_log.size())
        check("rr_product", 32'(rsp_log[k]), 32'(exp_prods[k]));
    end

    // Back-pressure: response held, no grants to a waiting requester
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'd7, 8'd9);
    set_req(1, 1'b1, 8'd4, 8'd5);
    wait_grant(g);
    check("bp_first_grant", 32'(g), 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    wait_rsp(ok);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_id", 32'(rsp_id), 0);
      check("bp_product", 32'(rsp_product), 63);
      check("bp_no_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant(g);
    check("bp_second_grant", 32'(g), 2);
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0);
    wait_rsp(ok);
    check("bp_second_id", 32'(rsp_id), 1);
    check("bp_second_product", 32'(rsp_product), 20);
    @(posedge clk); #1;

    // Reset while in WAIT
    set_req(0, 1'b1, 8'd5, 8'd6);
    wait_grant(g);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    wait_start(ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_rsp_id", 32'(rsp_id), 0);
    check("mid_rst_rsp_product", 32'(rsp_product), 0);
    check("mid_rst_mul_start", 32'(mul_start), 0);
    check("mid_rst_mul_ab", 32'({mul_a, mul_b}), 0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'd9, 8'd11);
    set_req(1, 1'b1, 8'd2, 8'd8);
    wait_grant(g);
    check("mid_rst_ptr_zero", 32'(g), 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0);
    wait_rsp(ok);
    check("mid_rst_new_id", 32'(rsp_id), 0);
    check("mid_rst_new_product", 32'(rsp_product), 99);
    @(posedge clk); #1;
    wait_grant(g);
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0);
    wait_rsp(ok);
    check("mid_rst_req1_product", 32'(rsp_product), 16);
    @(posedge clk); #1;

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: done never arrives
    force_low = 1'b1;
    set_req(2, 1'b1, 8'd3, 8'd3);
    wait_grant(g);
    @(posedge clk); #1;
    set_req(2, 1'b0, '0, '0);
    wait_start(ok);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", 32'(n), 17);
    check("tmo_err", 32'(rsp_err), 1);
    check("tmo_product", 32'(rsp_product), 0);
    check("tmo_id", 32'(rsp_id), 2);
    @(posedge clk); #1;
    force_low = 1'b0;
    do_req(3, 8'd6, 8'd7, id, p);
    check("tmo_recover_product", 32'(p), 42);
    check("tmo_err_cleared", 32'(rsp_err), 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
